// File: rtl/max_search_sched_if.sv
// Bundle of the requester, engine and result handshakes around max_search_sched.
// master: the scheduler's view. slave: the view of the surrounding sources,
// engine and result consumer.
interface max_search_sched_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 11,
  parameter int INDEX_WIDTH = 14,
  parameter int ID_WIDTH    = 2
);
  // Requester streams (flattened, requester i at [i*DATA_WIDTH +: DATA_WIDTH])
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  // Stream towards the shared engine
  logic                          eng_valid;
  logic                          eng_ready;
  logic [DATA_WIDTH-1:0]         eng_data;
  logic                          eng_last;
  // Result coming back from the engine
  logic                          eng_res_valid;
  logic                          eng_res_ready;
  logic [DATA_WIDTH-1:0]         eng_max_data;
  logic [INDEX_WIDTH-1:0]        eng_max_index;
  // Tagged result to the consumer
  logic                          res_valid;
  logic                          res_ready;
  logic [ID_WIDTH-1:0]           res_id;
  logic [DATA_WIDTH-1:0]         res_max_data;
  logic [INDEX_WIDTH-1:0]        res_max_index;

  modport master (
    input  req_valid, req_data, req_last,
    input  eng_ready, eng_res_valid, eng_max_data, eng_max_index,
    input  res_ready,
    output req_ready,
    output eng_valid, eng_data, eng_last, eng_res_ready,
    output res_valid, res_id, res_max_data, res_max_index
  );

  modport slave (
    output req_valid, req_data, req_last,
    output eng_ready, eng_res_valid, eng_max_data, eng_max_index,
    output res_ready,
    input  req_ready,
    input  eng_valid, eng_data, eng_last, eng_res_ready,
    input  res_valid, res_id, res_max_data, res_max_index
  );
endinterface

// File: rtl/max_search_sched.sv
// Round-robin scheduler sharing one streaming max-search engine among NUM_REQ
// frame sources. One frame in flight; the grant is held until the granted
// source's last beat, then the engine result is returned tagged with the ID.
// Optional feature: define MAX_SCHED_LEN_CHECK_EN to cut frames longer than
// DATA_NUM beats (forced eng_last, remaining beats dropped, sticky err_len).
// The interface instance must be built with the same NUM_REQ, DATA_WIDTH,
// INDEX_WIDTH and ID_WIDTH as this module.
module max_search_sched #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 11,
  parameter int DATA_NUM    = 15486,
  parameter int INDEX_WIDTH = $clog2(DATA_NUM),
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  max_search_sched_if.master    bus,
  output logic                  busy,
  output logic                  err_len
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_RES = 3'd3,
    S_OUT      = 3'd4
`ifdef MAX_SCHED_LEN_CHECK_EN
    , S_DISCARD = 3'd5
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]     res_id_q, res_id_d;
  logic [DATA_WIDTH-1:0]   res_max_data_q, res_max_data_d;
  logic [INDEX_WIDTH-1:0]  res_max_index_q, res_max_index_d;
  logic                    res_valid_q, res_valid_d;
  logic                    eng_res_ready_q, eng_res_ready_d;
  logic                    busy_q, busy_d;

`ifdef MAX_SCHED_LEN_CHECK_EN
  localparam int CNT_W = INDEX_WIDTH + 1;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    err_len_q, err_len_d;
  logic                    force_last;
  logic                    in_discard;
`endif

  logic [DATA_WIDTH-1:0]   lane_data [NUM_REQ];
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_valid;
  logic                    sel_last;
  logic                    in_stream;
  logic                    grant_ready;
  logic                    stream_hs;
  logic [ID_WIDTH-1:0]     pick;
  logic                    any_req;

  // Unpack the flattened requester data into one lane per source
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_data[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign sel_data  = lane_data[grant_q];
  assign sel_valid = bus.req_valid[grant_q];
  assign sel_last  = bus.req_last[grant_q];
  assign in_stream = (state_q == S_STREAM);

`ifdef MAX_SCHED_LEN_CHECK_EN
  // The DATA_NUM-th accepted beat is the last one the engine may see
  assign force_last  = (beat_cnt_q == CNT_W'(DATA_NUM - 1));
  assign in_discard  = (state_q == S_DISCARD);
  assign grant_ready = in_stream ? bus.eng_ready : in_discard;
  assign bus.eng_last = in_stream & (sel_last | force_last);
  assign err_len     = err_len_q;
`else
  assign grant_ready = in_stream & bus.eng_ready;
  assign bus.eng_last = in_stream & sel_last;
  assign err_len     = 1'b0;
`endif

  // Stream path is pure combinational muxing so STREAM has no bubbles
  assign bus.eng_valid = in_stream & sel_valid;
  assign bus.eng_data  = in_stream ? sel_data : '0;
  assign stream_hs     = bus.eng_valid & bus.eng_ready;

  // Only the granted requester ever sees ready
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = (grant_q == ID_WIDTH'(gi)) & grant_ready;
    end
  endgenerate

  assign bus.res_valid     = res_valid_q;
  assign bus.res_id        = res_id_q;
  assign bus.res_max_data  = res_max_data_q;
  assign bus.res_max_index = res_max_index_q;
  assign bus.eng_res_ready = eng_res_ready_q;
  assign busy              = busy_q;

  // Round-robin pick: first valid requester after last_grant, wrapping
  always_comb begin
    int cand;
    cand    = 0;
    pick    = '0;
    any_req = |bus.req_valid;
    // Walk from the farthest candidate down so the nearest one wins
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(last_grant_q) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (bus.req_valid[cand]) pick = ID_WIDTH'(cand);
    end
  end

  // Next-state and next-register computation for the frame FSM
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    res_id_d        = res_id_q;
    res_max_data_d  = res_max_data_q;
    res_max_index_d = res_max_index_q;
`ifdef MAX_SCHED_LEN_CHECK_EN
    beat_cnt_d      = beat_cnt_q;
    err_len_d       = err_len_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
`ifdef MAX_SCHED_LEN_CHECK_EN
        beat_cnt_d = '0;
`endif
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (stream_hs) begin
          if (sel_last) begin
            state_d = S_WAIT_RES;
          end
`ifdef MAX_SCHED_LEN_CHECK_EN
          else if (force_last) begin
            err_len_d = 1'b1;
            state_d   = S_DISCARD;
          end
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
`endif
        end
      end
`ifdef MAX_SCHED_LEN_CHECK_EN
      S_DISCARD: begin
        // Ready is forced high here, so valid alone is a handshake
        if (sel_valid && sel_last) state_d = S_WAIT_RES;
      end
`endif
      S_WAIT_RES: begin
        if (bus.eng_res_valid) begin
          res_max_data_d  = bus.eng_max_data;
          res_max_index_d = bus.eng_max_index;
          res_id_d        = grant_q;
          state_d         = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.res_ready) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered copies decoded from the next state
    busy_d          = (state_d != S_IDLE);
    eng_res_ready_d = (state_d == S_WAIT_RES);
    res_valid_d     = (state_d == S_OUT);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      grant_q         <= '0;
      last_grant_q    <= ID_WIDTH'(NUM_REQ - 1);
      res_id_q        <= '0;
      res_max_data_q  <= '0;
      res_max_index_q <= '0;
      res_valid_q     <= 1'b0;
      eng_res_ready_q <= 1'b0;
      busy_q          <= 1'b0;
`ifdef MAX_SCHED_LEN_CHECK_EN
      beat_cnt_q      <= '0;
      err_len_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      res_id_q        <= res_id_d;
      res_max_data_q  <= res_max_data_d;
      res_max_index_q <= res_max_index_d;
      res_valid_q     <= res_valid_d;
      eng_res_ready_q <= eng_res_ready_d;
      busy_q          <= busy_d;
`ifdef MAX_SCHED_LEN_CHECK_EN
      beat_cnt_q      <= beat_cnt_d;
      err_len_q       <= err_len_d;
`endif
    end
  end

endmodule

// File: tb/tb_max_search_sched.sv
// Directed bench for max_search_sched: the bench plays the requesters, the
// engine and the result consumer. Built with DATA_NUM=8 so the overlong-frame
// scenario is short; with MAX_SCHED_LEN_CHECK_EN undefined the same frame is
// expected to pass through whole.
module tb_max_search_sched;
  localparam int NR  = 4;
  localparam int DW  = 11;
  localparam int DN  = 8;
  localparam int IW  = $clog2(DN);
  localparam int IDW = $clog2(NR);
`ifdef MAX_SCHED_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err_len;

  always #5 clk = ~clk;

  max_search_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .ID_WIDTH(IDW)) bus ();

  max_search_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DATA_NUM(DN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .err_len (err_len)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fvals [16];

  // Record every beat the engine accepts
  logic [DW-1:0] mon_data [256];
  logic          mon_last [256];
  int            mon_n = 0;
  always @(posedge clk) begin
    if (rst_n && bus.eng_valid && bus.eng_ready && mon_n < 256) begin
      mon_data[mon_n] <= bus.eng_data;
      mon_last[mon_n] <= bus.eng_last;
      mon_n <= mon_n + 1;
    end
  end

  // Present fvals[0..n-1] on requester id until all are accepted
  task automatic drive_frame(input int id, input int n, output int first_cyc, output bit to);
    int idx;
    int cyc;
    idx = 0; cyc = 0; first_cyc = -1; to = 1'b0;
    while (idx < n && cyc < 100) begin
      @(negedge clk);
      bus.req_valid[id] = 1'b1;
      bus.req_data[id*DW +: DW] = fvals[idx];
      bus.req_last[id] = (idx == n - 1);
      #1;
      if (bus.req_ready[id]) begin
        if (first_cyc < 0) first_cyc = cyc;
        idx++;
      end
      cyc++;
    end
    if (idx < n) to = 1'b1;
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    bus.req_last[id]  = 1'b0;
    bus.req_data[id*DW +: DW] = '0;
  endtask

  // Act as the engine: wait for eng_res_ready, then present one result
  task automatic engine_respond(input logic [DW-1:0] mx, input logic [IW-1:0] mi, output bit to);
    int cyc;
    cyc = 0; to = 1'b0;
    while (!bus.eng_res_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.eng_res_ready) begin
      to = 1'b1;
    end else begin
      bus.eng_res_valid = 1'b1;
      bus.eng_max_data  = mx;
      bus.eng_max_index = mi;
      @(negedge clk);
      bus.eng_res_valid = 1'b0;
      bus.eng_max_data  = '0;
      bus.eng_max_index = '0;
    end
  endtask

  // Take the pending result in one cycle
  task automatic accept_result();
    $display("txn result id=%0d max=%0d idx=%0d valid=%0b", bus.res_id, bus.res_max_data,
             bus.res_max_index, bus.res_valid);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = '1;
    bus.req_last  = '1;
    bus.req_data  = '1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.eng_valid, bus.eng_last, bus.eng_res_ready, bus.res_valid, busy, err_len} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got %0h required 0", {bus.req_ready, bus.eng_valid, bus.eng_last,
               bus.eng_res_ready, bus.res_valid, busy, err_len});
    end
    checks++;
    if ({bus.eng_data, bus.res_id, bus.res_max_data, bus.res_max_index} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %0h required 0", {bus.eng_data, bus.res_id, bus.res_max_data, bus.res_max_index});
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_single();
    int fc;
    bit to;
    int base;
    bit ok;
    fvals[0] = 11'd3; fvals[1] = 11'd9; fvals[2] = 11'd2; fvals[3] = 11'd9; fvals[4] = 11'd1;
    base = mon_n;
    drive_frame(0, 5, fc, to);
    checks++;
    if (to || fc != 2) begin
      failures++;
      $display("FAIL single_latency: got first_cycle=%0d timeout=%0b required first_cycle=2", fc, to);
    end
    ok = (mon_n - base == 5);
    for (int i = 0; i < 5 && ok; i++)
      if (mon_data[base+i] !== fvals[i] || mon_last[base+i] !== (i == 4)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_beats: got %0d beats, required 5 beats 3,9,2,9,1 with last on 5th", mon_n - base);
    end
    #1;
    checks++;
    if ({busy, bus.eng_res_ready, bus.eng_valid} !== 3'b110) begin
      failures++;
      $display("FAIL single_wait_res: got busy/eng_res_ready/eng_valid=%b required 110",
               {busy, bus.eng_res_ready, bus.eng_valid});
    end
    engine_respond(11'd9, 3'd1, to);
    #1;
    checks++;
    if (to || {bus.res_valid, bus.res_id, bus.res_max_data, bus.res_max_index, bus.eng_res_ready} !==
        {1'b1, IDW'(0), DW'(9), IW'(1), 1'b0}) begin
      failures++;
      $display("FAIL single_result: got valid=%0b id=%0d max=%0d idx=%0d eng_res_ready=%0b timeout=%0b required 1/0/9/1/0",
               bus.res_valid, bus.res_id, bus.res_max_data, bus.res_max_index, bus.eng_res_ready, to);
    end
    accept_result();
    #1;
    checks++;
    if ({busy, bus.res_valid} !== 2'b00) begin
      failures++;
      $display("FAIL single_done: got busy/res_valid=%b required 00", {busy, bus.res_valid});
    end
  endtask

  task automatic test_round_robin();
    int fc;
    bit to;
    int base;
    bit ok;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // req1 and req3 both valid at the first arbitration after reset
    fvals[0] = 11'd4; fvals[1] = 11'd12;
    bus.req_valid[1] = 1'b1; bus.req_data[1*DW +: DW] = fvals[0]; bus.req_last[1] = 1'b0;
    bus.req_valid[3] = 1'b1; bus.req_data[3*DW +: DW] = 11'd5;    bus.req_last[3] = 1'b1;
    base = mon_n;
    drive_frame(1, 2, fc, to);
    ok = !to && (mon_n - base == 2) && mon_data[base] === 11'd4 && mon_data[base+1] === 11'd12 &&
         mon_last[base] === 1'b0 && mon_last[base+1] === 1'b1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_first_beats: got %0d beats first=%0d timeout=%0b required req1 beats 4,12", mon_n - base,
               mon_data[base], to);
    end
    engine_respond(11'd12, 3'd1, to);
    #1;
    checks++;
    if (to || bus.res_id !== IDW'(1) || bus.res_max_data !== DW'(12)) begin
      failures++;
      $display("FAIL rr_first_id: got id=%0d max=%0d required id=1 max=12", bus.res_id, bus.res_max_data);
    end
    // fresh req1 request while req3 is still waiting
    bus.req_valid[1] = 1'b1; bus.req_data[1*DW +: DW] = 11'd33; bus.req_last[1] = 1'b1;
    accept_result();
    fvals[0] = 11'd5;
    base = mon_n;
    drive_frame(3, 1, fc, to);
    checks++;
    if (to || (mon_n - base) != 1 || mon_data[base] !== 11'd5 || mon_last[base] !== 1'b1) begin
      failures++;
      $display("FAIL rr_second_beats: got %0d beats first=%0d required one req3 beat 5", mon_n - base, mon_data[base]);
    end
    engine_respond(11'd5, 3'd0, to);
    #1;
    checks++;
    if (to || bus.res_id !== IDW'(3)) begin
      failures++;
      $display("FAIL rr_second_id: got id=%0d required id=3", bus.res_id);
    end
    accept_result();
    fvals[0] = 11'd33;
    base = mon_n;
    drive_frame(1, 1, fc, to);
    checks++;
    if (to || (mon_n - base) != 1 || mon_data[base] !== 11'd33) begin
      failures++;
      $display("FAIL rr_third_beats: got %0d beats first=%0d required one req1 beat 33", mon_n - base, mon_data[base]);
    end
    engine_respond(11'd33, 3'd0, to);
    #1;
    checks++;
    if (to || bus.res_id !== IDW'(1)) begin
      failures++;
      $display("FAIL rr_third_id: got id=%0d required id=1", bus.res_id);
    end
    accept_result();
  endtask

  task automatic test_backpressure();
    int fc;
    bit to;
    fvals[0] = 11'd4; fvals[1] = 11'd6;
    drive_frame(2, 2, fc, to);
    engine_respond(11'd6, 3'd1, to);
    // another requester knocks while the result is held
    bus.req_valid[0] = 1'b1; bus.req_data[0 +: DW] = 11'd1; bus.req_last[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (to || {bus.res_valid, bus.res_id, bus.res_max_data, bus.res_max_index, bus.req_ready, bus.eng_res_ready, busy} !==
          {1'b1, IDW'(2), DW'(6), IW'(1), NR'(0), 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL bp_hold_c%0d: got valid=%0b id=%0d max=%0d idx=%0d req_ready=%b eng_res_ready=%0b busy=%0b required 1/2/6/1/0000/0/1",
                 c, bus.res_valid, bus.res_id, bus.res_max_data, bus.res_max_index, bus.req_ready, bus.eng_res_ready, busy);
      end
      @(negedge clk);
    end
    bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0; bus.req_data[0 +: DW] = '0;
    accept_result();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: got busy=%0b required 0", busy);
    end
  endtask

  task automatic test_stall();
    int pat [4] = '{1, 0, 0, 1};
    int cyc;
    int idx;
    int base;
    bit to;
    logic [NR-1:0] exp_rdy;
    fvals[0] = 11'd10; fvals[1] = 11'd20; fvals[2] = 11'd30; fvals[3] = 11'd40;
    base = mon_n;
    @(negedge clk);
    bus.eng_ready = 1'b0;
    bus.req_valid[0] = 1'b1; bus.req_data[0 +: DW] = fvals[0]; bus.req_last[0] = 1'b0;
    #1;
    cyc = 0;
    while (!bus.eng_valid && cyc < 10) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (bus.eng_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_grant: got eng_valid=%0b after %0d cycles required 1", bus.eng_valid, cyc);
    end
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 40) begin
      bus.eng_ready = pat[cyc % 4][0];
      bus.req_data[0 +: DW] = fvals[idx];
      bus.req_last[0] = (idx == 3);
      #1;
      exp_rdy = '0;
      exp_rdy[0] = pat[cyc % 4][0];
      checks++;
      if (bus.req_ready !== exp_rdy || bus.eng_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_mirror_c%0d: got req_ready=%b eng_valid=%0b required req_ready=%b eng_valid=1",
                 cyc, bus.req_ready, bus.eng_valid, exp_rdy);
      end
      if (bus.req_ready[0]) idx++;
      cyc++;
      @(negedge clk);
    end
    bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0; bus.req_data[0 +: DW] = '0;
    bus.eng_ready = 1'b1;
    checks++;
    if (idx != 4 || (mon_n - base) != 4 || mon_data[base] !== 11'd10 || mon_data[base+1] !== 11'd20 ||
        mon_data[base+2] !== 11'd30 || mon_data[base+3] !== 11'd40 ||
        {mon_last[base], mon_last[base+1], mon_last[base+2], mon_last[base+3]} !== 4'b0001) begin
      failures++;
      $display("FAIL stall_beats: got sent=%0d seen=%0d required 4 beats 10,20,30,40 with last on 4th", idx, mon_n - base);
    end
    engine_respond(11'd40, 3'd3, to);
    #1;
    checks++;
    if (to || {bus.res_id, bus.res_max_data, bus.res_max_index} !== {IDW'(0), DW'(40), IW'(3)}) begin
      failures++;
      $display("FAIL stall_result: got id=%0d max=%0d idx=%0d required 0/40/3", bus.res_id, bus.res_max_data, bus.res_max_index);
    end
    accept_result();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int fc;
    int base;
    bit to;
    @(negedge clk);
    bus.req_valid[1] = 1'b1; bus.req_data[1*DW +: DW] = 11'd11; bus.req_last[1] = 1'b0;
    #1;
    cyc = 0;
    while (!bus.req_ready[1] && cyc < 10) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    bus.req_data[1*DW +: DW] = 11'd12;
    @(negedge clk);
    bus.req_data[1*DW +: DW] = 11'd13;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.eng_valid, bus.eng_last, bus.eng_data, bus.eng_res_ready, bus.res_valid, busy, err_len} !== '0) begin
      failures++;
      $display("FAIL midrst_ctrl: got req_ready=%b eng_valid=%0b eng_data=%0d busy=%0b required all 0",
               bus.req_ready, bus.eng_valid, bus.eng_data, busy);
    end
    checks++;
    if ({bus.res_id, bus.res_max_data, bus.res_max_index} !== '0) begin
      failures++;
      $display("FAIL midrst_res: got id=%0d max=%0d idx=%0d required 0/0/0", bus.res_id, bus.res_max_data, bus.res_max_index);
    end
    // req1 is still asking; after reset req0 must win
    rst_n = 1'b1;
    fvals[0] = 11'd17;
    bus.req_valid[0] = 1'b1; bus.req_data[0 +: DW] = fvals[0]; bus.req_last[0] = 1'b1;
    base = mon_n;
    drive_frame(0, 1, fc, to);
    bus.req_valid[1] = 1'b0; bus.req_last[1] = 1'b0; bus.req_data[1*DW +: DW] = '0;
    checks++;
    if (to || (mon_n - base) != 1 || mon_data[base] !== 11'd17 || mon_last[base] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_regrant: got %0d beats first=%0d timeout=%0b required one req0 beat 17 with last",
               mon_n - base, mon_data[base], to);
    end
    engine_respond(11'd17, 3'd0, to);
    #1;
    checks++;
    if (to || {bus.res_valid, bus.res_id, bus.res_max_data, bus.res_max_index} !== {1'b1, IDW'(0), DW'(17), IW'(0)}) begin
      failures++;
      $display("FAIL midrst_result: got valid=%0b id=%0d max=%0d idx=%0d required 1/0/17/0",
               bus.res_valid, bus.res_id, bus.res_max_data, bus.res_max_index);
    end
    accept_result();
  endtask

  task automatic test_overlong();
    int fc;
    int base;
    int exp_n;
    bit to;
    bit ok;
    fvals[0] = 11'd5;  fvals[1] = 11'd3; fvals[2]  = 11'd8; fvals[3]  = 11'd1;
    fvals[4] = 11'd2;  fvals[5] = 11'd7; fvals[6]  = 11'd4; fvals[7]  = 11'd6;
    fvals[8] = 11'd50; fvals[9] = 11'd9; fvals[10] = 11'd9; fvals[11] = 11'd9;
    exp_n = LEN_CHK ? 8 : 12;
    base = mon_n;
    drive_frame(2, 12, fc, to);
    ok = !to && (mon_n - base == exp_n);
    for (int i = 0; i < exp_n && ok; i++)
      if (mon_data[base+i] !== fvals[i] || mon_last[base+i] !== (i == exp_n - 1)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL overlong_beats: got %0d beats timeout=%0b required %0d beats with last on beat %0d",
               mon_n - base, to, exp_n, exp_n);
    end
    #1;
    checks++;
    if (err_len !== LEN_CHK) begin
      failures++;
      $display("FAIL overlong_err: got err_len=%0b required %0b", err_len, LEN_CHK);
    end
    engine_respond(11'd8, 3'd2, to);
    #1;
    checks++;
    if (to || {bus.res_valid, bus.res_id, bus.res_max_data, bus.res_max_index} !== {1'b1, IDW'(2), DW'(8), IW'(2)}) begin
      failures++;
      $display("FAIL overlong_result: got valid=%0b id=%0d max=%0d idx=%0d required 1/2/8/2",
               bus.res_valid, bus.res_id, bus.res_max_data, bus.res_max_index);
    end
    accept_result();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({err_len, busy} !== {LEN_CHK, 1'b0}) begin
      failures++;
      $display("FAIL overlong_sticky: got err_len=%0b busy=%0b required err_len=%0b busy=0", err_len, busy, LEN_CHK);
    end
  endtask

  initial begin
    bus.req_valid     = '0;
    bus.req_data      = '0;
    bus.req_last      = '0;
    bus.eng_ready     = 1'b1;
    bus.eng_res_valid = 1'b0;
    bus.eng_max_data  = '0;
    bus.eng_max_index = '0;
    bus.res_ready     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_overlong();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound in case the design wedges somewhere unexpected
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/max_search_sched.md
# max_search_sched

Round-robin scheduler that shares one streaming max-search engine among `NUM_REQ` requesters. It sits between several frame sources (valid/ready/last streams) and the single engine. It grants one requester per frame and locks the grant until that requester's last beat. It then collects the engine's max value and index, and returns them tagged with the requester ID. Only one frame is in flight at a time.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 11: sample width.
- `DATA_NUM`, 15486: maximum beats per frame.
- `INDEX_WIDTH`, `$clog2(DATA_NUM)`: index width.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: requester ID width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester beat valid.
- `req_ready` out `NUM_REQ`: per-requester ready.
- `req_data` in `NUM_REQ*DATA_WIDTH`: flattened beats; requester i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last` in `NUM_REQ`: last beat of frame.
- `eng_valid` out 1: beat valid to engine.
- `eng_ready` in 1: engine input ready.
- `eng_data` out `DATA_WIDTH`: beat data to engine.
- `eng_last` out 1: beat last to engine.
- `eng_res_valid` in 1: engine result valid.
- `eng_res_ready` out 1: result accept to engine.
- `eng_max_data` in `DATA_WIDTH`: engine max value.
- `eng_max_index` in `INDEX_WIDTH`: engine max index, 0-based.
- `res_valid` out 1: tagged result valid.
- `res_ready` in 1: consumer ready.
- `res_id` out `ID_WIDTH`: granted requester.
- `res_max_data` out `DATA_WIDTH`: captured max value.
- `res_max_index` out `INDEX_WIDTH`: captured max index.
- `busy` out 1: state ≠ IDLE.
- `err_len` out 1: sticky overlong-frame flag (macro-dependent).

## Operation
- States: IDLE, GRANT, STREAM, DISCARD (macro only), WAIT_RES, OUT.
- **IDLE**
  - If any `req_valid` is high, pick the first set bit searching from `last_grant+1` modulo `NUM_REQ`.
  - Register the pick in `grant` and go to GRANT.
- **GRANT**: one cycle. Zero the beat counter, then go to STREAM.
- **STREAM**
  - `eng_valid = req_valid[grant]`, `eng_data` and `eng_last` are muxed from `grant`.
  - `req_ready[grant] = eng_ready`; all other `req_ready` are 0.
  - On a handshake with `req_last[grant]`, go to WAIT_RES.
- **WAIT_RES**
  - `eng_res_ready = 1`.
  - On `eng_res_valid`, capture data and index into the `res_*` registers, set `res_id = grant`, and go to OUT.
- **OUT**
  - `res_valid = 1`.
  - On `res_ready`, set `last_grant <= grant` and return to IDLE.
- `eng_res_ready` is 0 in every state except WAIT_RES. `eng_valid` is 0 outside STREAM. All `req_ready` are 0 outside STREAM/DISCARD.
- A requester that raises `req_valid` while another holds the grant waits. No beat is accepted from a non-granted requester.
- Requesters are not required to hold `req_valid` while not granted. Arbitration samples only in IDLE.

## Timing
- Reset values: state IDLE, `last_grant = NUM_REQ-1` (requester 0 wins first), `grant = 0`, `res_*` = 0, `err_len = 0`. All outputs are 0.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The engine is reset by the same `rst_n`.
- Request to first accepted beat: 2 cycles (IDLE→GRANT→STREAM).
- Stream-path ready/valid are combinational through the grant mux; there are no added bubbles in STREAM.
- `res_*` hold stable while `res_valid` is high and `res_ready` is low.
- Minimum gap from OUT handshake to the next grant: 1 cycle (the IDLE evaluation).
- A frame with `last` on its first beat is legal and yields index 0.

## Configuration
- **`MAX_SCHED_LEN_CHECK_EN` defined**
  - A beat counter (`INDEX_WIDTH+1` bits) counts STREAM handshakes.
  - On the `DATA_NUM`-th beat without `req_last`, force `eng_last = 1`, set `err_len` (sticky until reset), and go to DISCARD.
  - DISCARD: `req_ready[grant] = 1`, `eng_valid = 0`. Beats are dropped until a `req_last` handshake, then go to WAIT_RES.
- **Not defined**: no counter and no DISCARD state. `err_len` is tied to 0 and frames pass through unchecked.

## Test plan
- **Single frame**: req0 sends 3,9,2,9,1 with last on the 5th beat; engine returns 9/1 → `res_valid`, `res_id=0`, `res_max_data=9`, `res_max_index=1`; `busy` falls after the handshake.
- **Round-robin**: req1 and req3 valid simultaneously from reset → req1 frame served first, then req3. A fresh req1 request arriving during req3's frame is served after req3.
- **Backpressure**: `res_ready` low for 10 cycles in OUT → `res_*` stable. No `req_ready` is asserted and `eng_res_ready` stays 0 until the handshake.
- **Engine stall**: `eng_ready` toggling 1,0,0,1 during STREAM → `req_ready[grant]` mirrors it exactly; no beat is lost or duplicated.
- **Reset mid-frame**: `rst_n` low on the 3rd beat → next cycle all outputs 0, state IDLE. Next grant goes to req0.
- **Overlong frame, macro on**: `DATA_NUM=8`, req2 sends 12 beats → `eng_last` on beat 8, beats 9–12 dropped, `err_len=1`, result returned with `res_id=2`.
